// File: rtl/dmem_mmio_if.sv
// Bus between the core's memory stage and the data-side memory subsystem,
// plus the TX byte stream and timer interrupt that leave the block.
interface dmem_mmio_if;
  logic        MemWrite;
  logic [31:0] DataAdr;
  logic [31:0] WriteData;
  logic [31:0] ReadData;
  logic [7:0]  leds;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic        irq_timer;

  modport master (
    output MemWrite, DataAdr, WriteData, tx_ready,
    input  ReadData, leds, tx_data, tx_valid, irq_timer
  );

  modport slave (
    input  MemWrite, DataAdr, WriteData, tx_ready,
    output ReadData, leds, tx_data, tx_valid, irq_timer
  );
endinterface

// File: rtl/dmem_mmio.sv
// Data RAM plus MMIO block (LEDs, cycle counter, compare timer, TX FIFO)
// behind the core's memory stage. Loads are combinational, stores land on
// the rising edge.
module dmem_mmio #(
  parameter int unsigned RAM_WORDS  = 64,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input logic       clk,
  input logic       reset,
  dmem_mmio_if.slave bus
);
  localparam int unsigned AW = $clog2(RAM_WORDS);
  localparam int unsigned PW = $clog2(FIFO_DEPTH);
  localparam logic [PW:0]   CntOne  = (PW+1)'(1);
  localparam logic [PW:0]   CntFull = (PW+1)'(FIFO_DEPTH);
  localparam logic [PW-1:0] PtrOne  = PW'(1);

  typedef enum logic [2:0] {
    REG_LED, REG_CYCLE, REG_CMP, REG_CTRL, REG_TXD, REG_STAT, REG_CNT, REG_NONE
  } mmioReg_t;

  logic [31:0]   ram [RAM_WORDS];
  logic [7:0]    fifoMem [FIFO_DEPTH];

  logic [7:0]    ledReg;
  logic [31:0]   cycleCnt;
  logic [31:0]   timerCmp;
  logic [31:0]   timerCnt;
  logic          timerEn;
  logic          timerFlag;
  logic [PW-1:0] rdPtr;
  logic [PW-1:0] wrPtr;
  logic [PW:0]   count;
  logic          overflow;

  logic          ramHit;
  logic [AW-1:0] ramIdx;
  mmioReg_t      regSel;
  logic          wrLed, wrCmp, wrCtrl, wrStat, pushReq;
  logic          timerMatch;
  logic          full, empty, pop, push, ovfSet;
  logic [4:0]    countExt;
  logic [31:0]   readMux;
  logic [1:0]    unusedAdrBits;

  assign unusedAdrBits = bus.DataAdr[1:0];

  // Address decode: RAM window at the bottom, registers in the top 256 bytes.
  always_comb begin
    ramHit = (bus.DataAdr[31:AW+2] == '0);
    ramIdx = bus.DataAdr[AW+1:2];
    regSel = REG_NONE;
    if (bus.DataAdr[31:8] == 24'hFF_FFFF) begin
      case (bus.DataAdr[7:2])
        6'd0:    regSel = REG_LED;
        6'd1:    regSel = REG_CYCLE;
        6'd2:    regSel = REG_CMP;
        6'd3:    regSel = REG_CTRL;
        6'd4:    regSel = REG_TXD;
        6'd5:    regSel = REG_STAT;
        6'd6:    regSel = REG_CNT;
        default: regSel = REG_NONE;
      endcase
    end
  end

  assign wrLed   = bus.MemWrite && (regSel == REG_LED);
  assign wrCmp   = bus.MemWrite && (regSel == REG_CMP);
  assign wrCtrl  = bus.MemWrite && (regSel == REG_CTRL);
  assign wrStat  = bus.MemWrite && (regSel == REG_STAT);
  assign pushReq = bus.MemWrite && (regSel == REG_TXD);

  assign timerMatch = timerEn && (timerCnt == timerCmp);

  assign full   = (count == CntFull);
  assign empty  = (count == '0);
  assign pop    = !empty && bus.tx_ready;
  // A pop in the same edge frees the slot, so a full FIFO can still accept.
  assign push   = pushReq && (!full || pop);
  assign ovfSet = pushReq && full && !pop;

  // Data RAM store; contents are deliberately not reset.
  always_ff @(posedge clk) begin
    if (bus.MemWrite && ramHit) ram[ramIdx] <= bus.WriteData;
  end

  // FIFO storage; slot contents survive reset, only pointers are cleared.
  always_ff @(posedge clk) begin
    if (push) fifoMem[wrPtr] <= bus.WriteData[7:0];
  end

  // LED register and free-running cycle counter.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ledReg   <= '0;
      cycleCnt <= '0;
    end else begin
      if (wrLed) ledReg <= bus.WriteData[7:0];
      cycleCnt <= cycleCnt + 32'd1;
    end
  end

  // Compare timer: a match sets the flag and restarts the count; a hardware
  // set beats a software clear in the same edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      timerCmp  <= '0;
      timerCnt  <= '0;
      timerEn   <= 1'b0;
      timerFlag <= 1'b0;
    end else begin
      if (wrCmp) timerCmp <= bus.WriteData;
      if (wrCmp)        timerCnt <= '0;
      else if (timerEn) timerCnt <= timerMatch ? '0 : timerCnt + 32'd1;
      if (wrCtrl) timerEn <= bus.WriteData[0];
      if (timerMatch)                       timerFlag <= 1'b1;
      else if (wrCtrl && bus.WriteData[1])  timerFlag <= 1'b0;
    end
  end

  // TX FIFO pointers, occupancy and sticky overflow.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rdPtr    <= '0;
      wrPtr    <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (pop)  rdPtr <= rdPtr + PtrOne;
      if (push) wrPtr <= wrPtr + PtrOne;
      case ({push, pop})
        2'b10:   count <= count + CntOne;
        2'b01:   count <= count - CntOne;
        default: count <= count;
      endcase
      if (ovfSet)      overflow <= 1'b1;
      else if (wrStat) overflow <= 1'b0;
    end
  end

  assign countExt = 5'(count);

  // Zero-latency load mux; unmapped and write-only locations read as zero.
  always_comb begin
    readMux = '0;
    if (ramHit) begin
      readMux = ram[ramIdx];
    end else begin
      case (regSel)
        REG_LED:   readMux = {24'b0, ledReg};
        REG_CYCLE: readMux = cycleCnt;
        REG_CMP:   readMux = timerCmp;
        REG_CTRL:  readMux = {30'b0, timerFlag, timerEn};
        REG_STAT:  readMux = {23'b0, countExt, 1'b0, overflow, empty, full};
        REG_CNT:   readMux = timerCnt;
        default:   readMux = '0;
      endcase
    end
  end

  assign bus.ReadData  = readMux;
  assign bus.leds      = ledReg;
  assign bus.tx_data   = fifoMem[rdPtr];
  assign bus.tx_valid  = !empty;
  assign bus.irq_timer = timerFlag && timerEn;
endmodule

// File: tb/tb_dmem_mmio.sv
// Bench for dmem_mmio: directed scenarios with literal expectations, then
// randomized traffic checked each cycle against a transaction-level model.
`timescale 1ns/100ps
module tb_dmem_mmio;
  localparam int unsigned RAM_WORDS  = 64;
  localparam int unsigned FIFO_DEPTH = 4;

  localparam logic [31:0] A_LED  = 32'hFFFF_FF00;
  localparam logic [31:0] A_CYC  = 32'hFFFF_FF04;
  localparam logic [31:0] A_CMP  = 32'hFFFF_FF08;
  localparam logic [31:0] A_CTRL = 32'hFFFF_FF0C;
  localparam logic [31:0] A_TXD  = 32'hFFFF_FF10;
  localparam logic [31:0] A_STAT = 32'hFFFF_FF14;
  localparam logic [31:0] A_CNT  = 32'hFFFF_FF18;

  logic clk = 1'b0;
  logic reset = 1'b1;
  dmem_mmio_if bus ();

  dmem_mmio #(.RAM_WORDS(RAM_WORDS), .FIFO_DEPTH(FIFO_DEPTH)) dut (
    .clk(clk), .reset(reset), .bus(bus)
  );

  always #10 clk = ~clk;

  int nChecks = 0;
  int nFails  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nChecks++;
    if (act !== exp) begin
      nFails++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  logic [31:0] mRam [RAM_WORDS];
  bit          mKnown [RAM_WORDS];
  logic [7:0]  mLeds;
  logic [31:0] mCycle, mCmp, mCnt;
  logic        mEn, mFlag, mOvf;
  logic [7:0]  mQ [$];

  function automatic logic [31:0] mRead(input logic [31:0] adr, output bit known);
    logic [31:0] a;
    logic [31:0] v;
    int sz;
    a = {adr[31:2], 2'b00};
    known = 1'b1;
    v = '0;
    sz = mQ.size();
    if (a < RAM_WORDS * 4) begin
      known = mKnown[a / 4];
      v = mRam[a / 4];
    end else begin
      case (a)
        A_LED:  v = {24'b0, mLeds};
        A_CYC:  v = mCycle;
        A_CMP:  v = mCmp;
        A_CTRL: v = {30'b0, mFlag, mEn};
        A_STAT: begin
          v[0] = (sz == FIFO_DEPTH);
          v[1] = (sz == 0);
          v[2] = mOvf;
          v[8:4] = 5'(sz);
        end
        A_CNT:  v = mCnt;
        default: v = '0;
      endcase
    end
    return v;
  endfunction

  logic [31:0] ma, mWd, nCnt;
  logic        mWe, popNow, hit, nEn, nFlag;
  logic [7:0]  dropped;

  // Model advances one transaction per edge from the pre-edge state.
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      mLeds = '0; mCycle = '0; mCmp = '0; mCnt = '0;
      mEn = 1'b0; mFlag = 1'b0; mOvf = 1'b0;
      mQ.delete();
    end else begin
      ma = {bus.DataAdr[31:2], 2'b00};
      mWe = bus.MemWrite;
      mWd = bus.WriteData;
      popNow = (mQ.size() != 0) && bus.tx_ready;
      hit = mEn && (mCnt == mCmp);
      nCnt = mEn ? (hit ? 32'd0 : mCnt + 32'd1) : mCnt;
      nEn = mEn;
      nFlag = mFlag;
      if (mWe) begin
        if (ma < RAM_WORDS * 4) begin
          mRam[ma / 4] = mWd;
          mKnown[ma / 4] = 1'b1;
        end
        case (ma)
          A_LED:  mLeds = mWd[7:0];
          A_CMP:  begin mCmp = mWd; nCnt = 32'd0; end
          A_CTRL: begin nEn = mWd[0]; if (mWd[1]) nFlag = 1'b0; end
          A_STAT: mOvf = 1'b0;
          default: ;
        endcase
      end
      if (hit) nFlag = 1'b1;
      if (popNow) dropped = mQ.pop_front();
      if (mWe && ma == A_TXD) begin
        if (mQ.size() < FIFO_DEPTH) mQ.push_back(mWd[7:0]);
        else mOvf = 1'b1;
      end
      mCnt = nCnt;
      mEn = nEn;
      mFlag = nFlag;
      mCycle = mCycle + 32'd1;
    end
  end

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    logic [31:0] e;
    bit known;
    if (reset === 1'b0) begin
      e = mRead(bus.DataAdr, known);
      if (known) chk("ReadData", bus.ReadData, e);
      chk("leds", {24'b0, bus.leds}, {24'b0, mLeds});
      chk("tx_valid", {31'b0, bus.tx_valid}, {31'b0, mQ.size() != 0});
      if (mQ.size() != 0) chk("tx_data", {24'b0, bus.tx_data}, {24'b0, mQ[0]});
      chk("irq_timer", {31'b0, bus.irq_timer}, {31'b0, mFlag & mEn});
    end
  end

  // ---------------- stimulus ----------------
  task automatic setBus(input logic we, input logic [31:0] adr, input logic [31:0] wd);
    bus.MemWrite = we;
    bus.DataAdr = adr;
    bus.WriteData = wd;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] adr, wd;
    bit known;
    int sel, readyBias;
    setBus(1'b0, '0, '0);
    bus.tx_ready = 1'b0;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    setBus(1'b0, A_CYC, '0); #1 chk("rst_cycle", bus.ReadData, 32'h0);
    setBus(1'b0, A_STAT, '0); #1 chk("rst_status", bus.ReadData, 32'h2);
    chk("rst_leds", {24'b0, bus.leds}, 32'h0);
    chk("rst_txvalid", {31'b0, bus.tx_valid}, 32'h0);
    chk("rst_irq", {31'b0, bus.irq_timer}, 32'h0);
    #1 reset = 1'b0;

    // CYCLE: five edges after release reads 5, then 6, write ignored
    repeat (5) tick();
    setBus(1'b0, A_CYC, '0); #1 chk("cycle5", bus.ReadData, 32'd5);
    tick();
    setBus(1'b1, A_CYC, 32'h1234); #1 chk("cycle6", bus.ReadData, 32'd6);
    tick();
    setBus(1'b0, A_CYC, '0); #1 chk("cycle7_ro", bus.ReadData, 32'd7);
    tick();

    // RAM store/load, same-cycle old value, byte-offset aliasing
    setBus(1'b1, 32'h10, 32'h1111_1111); tick();
    setBus(1'b1, 32'h10, 32'hDEAD_BEEF); #1 chk("ram_old", bus.ReadData, 32'h1111_1111);
    tick();
    setBus(1'b0, 32'h10, '0); #1 chk("ram_10", bus.ReadData, 32'hDEAD_BEEF);
    setBus(1'b0, 32'h11, '0); #1 chk("ram_11", bus.ReadData, 32'hDEAD_BEEF);
    setBus(1'b0, 32'h13, '0); #1 chk("ram_13", bus.ReadData, 32'hDEAD_BEEF);
    tick();

    // Timer: CMP=3, enable, irq four edges later; clear and re-set
    setBus(1'b1, A_CMP, 32'd3); tick();
    setBus(1'b1, A_CTRL, 32'd1); tick();
    setBus(1'b0, A_CNT, '0);
    repeat (3) tick();
    chk("irq_pre", {31'b0, bus.irq_timer}, 32'h0);
    tick();
    chk("irq_set", {31'b0, bus.irq_timer}, 32'h1);
    setBus(1'b1, A_CTRL, 32'd3); tick();
    chk("irq_clr", {31'b0, bus.irq_timer}, 32'h0);
    setBus(1'b0, A_CTRL, '0); #1 chk("ctrl_rd", bus.ReadData, 32'h1);
    repeat (2) tick();
    chk("irq_wait", {31'b0, bus.irq_timer}, 32'h0);
    tick();
    chk("irq_reset", {31'b0, bus.irq_timer}, 32'h1);
    setBus(1'b1, A_CTRL, 32'd2); tick();

    // FIFO fill and overflow
    for (int i = 0; i < 5; i++) begin
      setBus(1'b1, A_TXD, 32'h41 + 32'(i)); tick();
    end
    setBus(1'b0, A_STAT, '0); #1 chk("stat_full", bus.ReadData, 32'h45);
    chk("model_stat_full", mRead(A_STAT, known), 32'h45);
    bus.tx_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1 chk("drain_data", {24'b0, bus.tx_data}, 32'h41 + 32'(i));
      chk("drain_valid", {31'b0, bus.tx_valid}, 32'h1);
      tick();
    end
    #1 chk("drained", {31'b0, bus.tx_valid}, 32'h0);
    chk("stat_empty_ovf", bus.ReadData, 32'h6);
    setBus(1'b1, A_STAT, '0); tick();
    setBus(1'b0, A_STAT, '0); #1 chk("ovf_clr", bus.ReadData, 32'h2);
    bus.tx_ready = 1'b0;
    tick();

    // Simultaneous push and pop on a full FIFO
    for (int i = 0; i < 4; i++) begin
      setBus(1'b1, A_TXD, 32'h61 + 32'(i)); tick();
    end
    setBus(1'b1, A_TXD, 32'h55);
    bus.tx_ready = 1'b1;
    tick();
    bus.tx_ready = 1'b0;
    setBus(1'b0, A_STAT, '0); #1 chk("stat_pushpop", bus.ReadData, 32'h41);
    chk("model_pushpop", mRead(A_STAT, known), 32'h41);
    bus.tx_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1 chk("pp_data", {24'b0, bus.tx_data}, (i == 3) ? 32'h55 : 32'h62 + 32'(i));
      tick();
    end
    #1 chk("pp_empty", {31'b0, bus.tx_valid}, 32'h0);
    bus.tx_ready = 1'b0;

    // Reset in the middle of activity
    setBus(1'b1, A_LED, 32'hA5); tick();
    for (int i = 0; i < 3; i++) begin
      setBus(1'b1, A_TXD, 32'h70 + 32'(i)); tick();
    end
    setBus(1'b1, A_CMP, 32'd2); tick();
    setBus(1'b1, A_CTRL, 32'd1); tick();
    setBus(1'b0, A_CYC, '0);
    repeat (4) tick();
    chk("pre_leds", {24'b0, bus.leds}, 32'hA5);
    chk("pre_irq", {31'b0, bus.irq_timer}, 32'h1);
    chk("pre_valid", {31'b0, bus.tx_valid}, 32'h1);
    #1 reset = 1'b1;
    #1 chk("mid_leds", {24'b0, bus.leds}, 32'h0);
    chk("mid_valid", {31'b0, bus.tx_valid}, 32'h0);
    chk("mid_irq", {31'b0, bus.irq_timer}, 32'h0);
    chk("mid_cycle", bus.ReadData, 32'h0);
    bus.DataAdr = A_CNT; #1 chk("mid_tcnt", bus.ReadData, 32'h0);
    bus.DataAdr = A_CMP; #1 chk("mid_tcmp", bus.ReadData, 32'h0);
    #1 reset = 1'b0;
    tick();

    // Randomized traffic, checked by the per-cycle compare process
    readyBias = 2;
    for (int n = 0; n < 3000; n++) begin
      if (n % 200 == 0) readyBias = $urandom_range(0, 4);
      sel = $urandom_range(0, 9);
      wd = $urandom;
      case (sel)
        0, 1: adr = ($urandom_range(0, 15) << 2);
        2: adr = A_LED;
        3: adr = A_CYC;
        4: begin adr = A_CMP; wd = $urandom_range(0, 6); end
        5: adr = A_CTRL;
        6: adr = A_TXD;
        7: adr = A_STAT;
        8: adr = A_CNT;
        default: begin
          case ($urandom_range(0, 3))
            0: adr = 32'hFFFF_FF1C;
            1: adr = 32'hFFFF_FE00;
            2: adr = RAM_WORDS * 4;
            default: adr = $urandom | 32'h8000_0000;
          endcase
        end
      endcase
      if (sel != 0 && sel != 1) adr[1:0] = 2'($urandom_range(0, 3));
      setBus(1'($urandom_range(0, 1)), adr, wd);
      bus.tx_ready = ($urandom_range(0, 3) < readyBias);
      if ($urandom_range(0, 399) == 0) begin
        #1 reset = 1'b1;
        #4 reset = 1'b0;
      end
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end
endmodule

// File: doc/dmem_mmio.md
# dmem_mmio

Data-side memory subsystem that sits directly downstream of the pipelined RISC-V core's memory stage. It consumes the core's MemWrite, DataAdr and WriteData, and returns ReadData in the same cycle. It contains a word-addressed data RAM and a small memory-mapped I/O block:
- LED register
- free-running cycle counter
- compare timer with interrupt flag
- 4-entry transmit FIFO with a ready/valid output port

## Interface
- RAM_WORDS, 64: data RAM depth in 32-bit words; power of two, 16..4096.
- FIFO_DEPTH, 4: TX FIFO entries; power of two, 2..16.
- clk  in  1  single clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-high; clears all registers listed below except RAM contents.
- MemWrite  in  1  write strobe from the memory stage.
- DataAdr  in  32  byte address; bits [1:0] ignored (word-only accesses).
- WriteData  in  32  store data.
- ReadData  out  32  load data; combinational from DataAdr and current state.
- leds  out  8  LED register value.
- tx_data  out  8  FIFO head byte.
- tx_valid  out  1  FIFO non-empty.
- tx_ready  in  1  consumer accepts the head when high together with tx_valid.
- irq_timer  out  1  timer flag AND timer enable.

## Operation
Address map (word aligned):
- 0x0000_0000 .. RAM_WORDS*4-1: RAM, indexed by DataAdr[log2(RAM_WORDS)+1:2]; read/write.
- 0xFFFF_FF00 LED: RW; low 8 bits stored, upper read bits 0.
- 0xFFFF_FF04 CYCLE: RO 32-bit counter; +1 every cycle, wraps 0xFFFF_FFFF -> 0.
- 0xFFFF_FF08 TIMER_CMP: RW 32-bit. A write also zeroes TIMER_CNT.
- 0xFFFF_FF0C TIMER_CTRL:
  - read: bit0 enable, bit1 flag, other bits 0.
  - write: enable <= WriteData[0]; WriteData[1]=1 clears flag.
- 0xFFFF_FF10 TX_DATA: WO; write pushes WriteData[7:0]; reads 0.
- 0xFFFF_FF14 TX_STATUS:
  - read: bit0 full, bit1 empty, bit2 overflow (sticky), bits[8:4] count, rest 0.
  - any write clears overflow.
- 0xFFFF_FF18 TIMER_CNT: RO.
- All other addresses: read 0, writes ignored; no other state changes.

Writes to RO registers are ignored.

Timer:
- While enable=1: at each edge, if TIMER_CNT == TIMER_CMP then flag <= 1 and TIMER_CNT <= 0; otherwise TIMER_CNT += 1.
- While enable=0: TIMER_CNT holds.
- TIMER_CMP = 0 with enable=1 sets flag every cycle.
- A flag set and a software clear in the same cycle: set wins.

TX FIFO:
- Circular buffer with read pointer, write pointer and count.
- Push when TX_DATA is written and (not full, or a pop occurs in the same cycle).
- A push to a full FIFO without a simultaneous pop is dropped and sets overflow.
- Pop when tx_valid && tx_ready.
- Simultaneous push and pop: count unchanged, both pointers advance.
- Pointers wrap modulo FIFO_DEPTH.
- tx_data = entry at read pointer. When empty, tx_data holds the last stored slot value and must not be relied on.

Reset values:
- leds 0, CYCLE 0, TIMER_CMP 0, TIMER_CNT 0, enable 0, flag 0, overflow 0.
- FIFO pointers and count 0, so tx_valid 0 and irq_timer 0.
- ReadData follows the reset register values for MMIO addresses.
- RAM contents are not reset and are undefined until written.

## Timing
- Load latency 0: ReadData is valid in the same cycle DataAdr is presented.
- Store takes effect at the rising edge where MemWrite=1. A same-cycle read of that address returns the old value; the following cycle returns the new value.
- CYCLE read returns the pre-edge value, so back-to-back reads in consecutive cycles differ by 1.
- irq_timer rises the cycle after the edge on which TIMER_CNT == TIMER_CMP.
- tx_valid rises the cycle after the first push into an empty FIFO and falls the cycle after the last pop.
- Asserting reset mid-operation clears state immediately and discards FIFO contents. The first edge after reset deasserts is a normal cycle.

## Test plan
- RAM: write 0xDEAD_BEEF to 0x0000_0010, then read 0x10 -> 0xDEAD_BEEF. Same-cycle read during the write returns the old value. Reads of 0x10, 0x11 and 0x13 are identical.
- CYCLE: release reset, read 0xFFFF_FF04 on cycles 5 and 6 after release -> values differ by exactly 1. Writing 0x1234 to CYCLE has no effect.
- Timer: write CMP=3 and CTRL=1 -> irq_timer=1 four cycles later. Write CTRL=0b11 -> flag clears and irq_timer drops the next cycle, then the flag re-sets after 4 more cycles.
- FIFO fill/overflow: tx_ready=0, push 0x41..0x45 -> STATUS full=1, count=4, overflow=1. Raise tx_ready -> bytes 0x41..0x44 appear in order, then empty=1.
- Simultaneous push/pop: FIFO full, tx_ready=1, push 0x55 in the same cycle -> count stays 4, overflow stays 0, 0x55 emerges last.
- Reset mid-stream: 3 bytes queued, timer running, LED=0xA5; pulse reset between edges -> tx_valid, leds, irq_timer and all counters go to 0 immediately.
